// File: rtl/rec_play_pkg.sv
// Shared definitions for the note record/playback sequencer:
// state encoding and the default memory/tick geometry.
package rec_play_pkg;

    localparam int ADDR_W_DEF   = 9;
    localparam int DATA_W_DEF   = 8;
    localparam int TICK_DIV_DEF = 2_000_000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_e;

    // Plain-vector copies of the states for legacy code that keeps the
    // state register as a bare logic vector.
    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_REC  = S_REC;
    localparam logic [1:0] ST_PLAY = S_PLAY;

endpackage

// File: rtl/rec_play_ctrl_tick_gen.sv
// Note-step tick generator: one-cycle pulse every TICK_DIV clocks.
// 'clr' holds the divider at zero so the owner can restart the step
// phase on every state entry; the first pulse then lands TICK_DIV
// cycles after clr drops.
module tick_gen #(
    parameter int TICK_DIV = 2_000_000
) (
    input  logic clk100mhz,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter with a registered terminal-count pulse.
    always_ff @(posedge clk100mhz) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer for the note memory. A single-clock FSM
// (IDLE/REC/PLAY) steps on a divided tick: in REC it writes one note per
// tick into the async-read distributed RAM and counts the take length;
// in PLAY it reads the take back one note per tick into 'salida'.
// Build option: define PLAY_LOOP_EN to honour loop_sw (playback wraps
// to the start of the take); otherwise playback is always one-shot.
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic              clk100mhz,
    input  logic              rst,
    input  logic              rec_sw,
    input  logic              play_sw,
    input  logic              loop_sw,
    input  logic [DATA_W-1:0] nota,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_spo,
    output logic [DATA_W-1:0] salida,
    output logic              busy,
    output logic [ADDR_W:0]   take_len
);

    // Take length that means "one slot left": the next write fills memory.
    localparam logic [ADDR_W:0] LAST_LEN = {1'b0, {ADDR_W{1'b1}}};

    logic [1:0] state;
    logic       tick;
    logic       clr;
    logic       loop_on;
    logic       last_addr;

`ifdef PLAY_LOOP_EN
    assign loop_on = loop_sw;
`else
    logic unused_loop_sw;
    assign unused_loop_sw = loop_sw;
    assign loop_on        = 1'b0;
`endif

    // The step divider is held at zero in IDLE so each REC/PLAY entry
    // starts a fresh step period.
    assign clr = (state == ST_IDLE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk100mhz (clk100mhz),
        .rst       (rst),
        .clr       (clr),
        .tick      (tick)
    );

    // Write strobe and data are presented in the tick cycle itself, with
    // the address register already pointing at the slot being filled.
    // A falling rec_sw wins over a coincident tick, so no write occurs.
    always_comb begin
        mem_we = (state == ST_REC) && tick && rec_sw && !rst;
        mem_d  = mem_we ? nota : '0;
    end

    assign last_addr = ({1'b0, mem_addr} == (take_len - (ADDR_W + 1)'(1)));

    // Main sequencer: state, address pointer, take length and playback.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            take_len <= '0;
            salida   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rec_sw) begin
                        state    <= ST_REC;
                        mem_addr <= '0;
                        take_len <= '0;
                        busy     <= 1'b1;
                    end else if (play_sw && (take_len != '0)) begin
                        state    <= ST_PLAY;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_REC: begin
                    if (!rec_sw) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        take_len <= take_len + (ADDR_W + 1)'(1);
                        if (take_len == LAST_LEN) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (!play_sw || rec_sw) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        salida <= mem_spo;
                        if (last_addr) begin
                            if (loop_on) begin
                                mem_addr <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Testbench for rec_play_ctrl with a small geometry (8-deep memory,
// 4-cycle note step). A behavioural model of the take (note array, length,
// play pointer, cycles-in-mode age) predicts every output each cycle.
module tb_rec_play_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int TD    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          recSw = 1'b0;
    logic          playSw = 1'b0;
    logic          loopSw = 1'b0;
    logic [DW-1:0] nota = '0;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [DW-1:0] memD;
    logic [DW-1:0] memSpo;
    logic [DW-1:0] salida;
    logic          busy;
    logic [AW:0]   takeLen;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    int writeCount = 0;

    rec_play_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TICK_DIV (TD)
    ) dut (
        .clk100mhz (clk),
        .rst       (rst),
        .rec_sw    (recSw),
        .play_sw   (playSw),
        .loop_sw   (loopSw),
        .nota      (nota),
        .mem_addr  (memAddr),
        .mem_we    (memWe),
        .mem_d     (memD),
        .mem_spo   (memSpo),
        .salida    (salida),
        .busy      (busy),
        .take_len  (takeLen)
    );

    always #5 clk = ~clk;

    // Distributed RAM stand-in: synchronous write, asynchronous read.
    logic [DW-1:0] benchMem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) benchMem[i] = '0;
    always @(posedge clk) if (memWe) benchMem[memAddr] <= memD;
    assign memSpo = benchMem[memAddr];

    // Behavioural model: mode 0 idle, 1 recording, 2 playing.
    int            mMode = 0;
    int            mAge = 0;
    int            mAddr = 0;
    int            mLen = 0;
    logic [DW-1:0] mSalida = '0;
    logic [DW-1:0] mTake [DEPTH];
    logic          mLoop;

`ifdef PLAY_LOOP_EN
    assign mLoop = loopSw;
`else
    assign mLoop = 1'b0;
`endif

    function automatic bit stepDue(input int age);
        return (age > 0) && (age % TD == 0);
    endfunction

    always @(posedge clk) begin
        bit t;
        t = stepDue(mAge);
        if (rst) begin
            mMode = 0; mAge = 0; mAddr = 0; mLen = 0; mSalida = '0;
        end else if (mMode == 0) begin
            mAge = 0;
            if (recSw) begin
                mMode = 1; mAddr = 0; mLen = 0;
            end else if (playSw && mLen != 0) begin
                mMode = 2; mAddr = 0;
            end
        end else if (mMode == 1) begin
            if (!recSw) mMode = 0;
            else begin
                mAge++;
                if (t) begin
                    mTake[mAddr] = nota;
                    mLen++;
                    if (mLen == DEPTH) mMode = 0;
                    else mAddr++;
                end
            end
        end else begin
            if (!playSw || recSw) mMode = 0;
            else begin
                mAge++;
                if (t) begin
                    mSalida = mTake[mAddr];
                    if (mAddr == mLen - 1) begin
                        if (mLoop) mAddr = 0;
                        else mMode = 0;
                    end else mAddr++;
                end
            end
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic l, input logic [DW-1:0] n);
        recSw = r; playSw = p; loopSw = l; nota = n;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic expWe;
            expWe = (mMode == 1) && stepDue(mAge) && recSw && !rst;
            checkOutput("busy", busy, (mMode != 0));
            checkOutput("mem_addr", memAddr, mAddr);
            checkOutput("take_len", takeLen, mLen);
            checkOutput("salida", salida, mSalida);
            checkOutput("mem_we", memWe, expWe);
            checkOutput("mem_d", memD, expWe ? nota : 8'h00);
            if (memWe === 1'b1) writeCount++;
        end
    end

    // Record n notes (first, first+step, ...) and release rec_sw after the last write.
    task automatic recordTake(input int n, input logic [DW-1:0] first, input logic [DW-1:0] step);
        logic [DW-1:0] cur;
        cur = first;
        applyStimulus(1'b1, 1'b0, 1'b0, cur);
        for (int i = 0; i < n; i++) begin
            bit got;
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (memWe === 1'b1) got = 1;
            end
            checkOutput("rec_write_seen", got, 1);
            nextCycle();
            cur = cur + step;
            nota = cur;
        end
        recSw = 1'b0;
    endtask

    logic [DW-1:0] seen[$];

    // Collect distinct successive salida values until count reached or budget spent.
    task automatic playCollect(input int count, input int budget);
        logic [DW-1:0] last;
        seen.delete();
        last = salida;
        for (int c = 0; c < budget && seen.size() < count; c++) begin
            @(negedge clk);
            if (salida !== last) begin
                seen.push_back(salida);
                last = salida;
            end
        end
        checkOutput("play_count", seen.size(), count);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1 checkEn = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_take_len", takeLen, 0);
        checkOutput("reset_salida", salida, 0);
        checkOutput("reset_mem_addr", memAddr, 0);
        checkOutput("reset_mem_we", memWe, 0);

        // Play with empty take is ignored.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (6) nextCycle();
        checkOutput("empty_play_busy", busy, 0);
        checkOutput("empty_play_salida", salida, 0);
        playSw = 1'b0;
        nextCycle();

        // Three-note take.
        recordTake(3, 8'h11, 8'h11);
        repeat (3) nextCycle();
        checkOutput("rec3_take_len", takeLen, 3);
        checkOutput("rec3_busy", busy, 0);
        checkOutput("rec3_mem0", benchMem[0], 8'h11);
        checkOutput("rec3_mem1", benchMem[1], 8'h22);
        checkOutput("rec3_mem2", benchMem[2], 8'h33);

        // One-shot playback.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        playCollect(3, 40);
        checkOutput("oneshot_v0", seen.size() > 0 ? seen[0] : 8'hxx, 8'h11);
        checkOutput("oneshot_v1", seen.size() > 1 ? seen[1] : 8'hxx, 8'h22);
        checkOutput("oneshot_v2", seen.size() > 2 ? seen[2] : 8'hxx, 8'h33);
        checkOutput("oneshot_end_busy", busy, 0);
        playSw = 1'b0;
        repeat (3) nextCycle();
        checkOutput("oneshot_idle_busy", busy, 0);

        // Playback with loop_sw set.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
`ifdef PLAY_LOOP_EN
        playCollect(5, 60);
        checkOutput("loop_v2", seen.size() > 2 ? seen[2] : 8'hxx, 8'h33);
        checkOutput("loop_v3", seen.size() > 3 ? seen[3] : 8'hxx, 8'h11);
        checkOutput("loop_v4", seen.size() > 4 ? seen[4] : 8'hxx, 8'h22);
        checkOutput("loop_still_busy", busy, 1);
`else
        playCollect(3, 40);
        checkOutput("noloop_v2", seen.size() > 2 ? seen[2] : 8'hxx, 8'h33);
        checkOutput("noloop_end_busy", busy, 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) nextCycle();
        checkOutput("loop_stop_busy", busy, 0);

        // rec_sw and play_sw together: record wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        begin
            bit got;
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (memWe === 1'b1) got = 1;
            end
            checkOutput("both_sw_records", got, 1);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) nextCycle();
        checkOutput("both_sw_take_len", takeLen, 1);

        // Full take: rec_sw held until the sequencer returns to IDLE on its own.
        writeCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h40);
        begin
            bit done;
            done = 0;
            nextCycle();
            for (int c = 0; c < 60 && !done; c++) begin
                @(negedge clk);
                if (memWe === 1'b1) begin
                    @(posedge clk);
                    #1 nota = nota + 8'h01;
                end else if (busy === 1'b0) begin
                    done = 1;
                    #1 recSw = 1'b0;
                end
            end
            checkOutput("full_auto_idle", done, 1);
        end
        repeat (12) nextCycle();
        checkOutput("full_writes", writeCount, 8);
        checkOutput("full_take_len", takeLen, 8);
        checkOutput("full_busy", busy, 0);
        checkOutput("full_mem0", benchMem[0], 8'h40);
        checkOutput("full_mem7", benchMem[7], 8'h47);

        // Reset during playback discards the take.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (7) nextCycle();
        checkOutput("play_before_rst_busy", busy, 1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        playSw = 1'b0;
        repeat (2) nextCycle();
        checkOutput("rst_play_take_len", takeLen, 0);
        checkOutput("rst_play_busy", busy, 0);
        checkOutput("rst_play_salida", salida, 0);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
